// File: rtl/encoder_8_to_3.sv
// One-hot to binary encoder with a combinational index path and a registered copy.
// Optional saturating error-cycle counter enabled by defining ENCODER_ERR_CNT_EN.
module encoder_8_to_3 #(
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width-1:0]         in,
  output logic [$clog2(width)-1:0] out,
  output logic                     valid,
  output logic                     err,
  output logic [$clog2(width)-1:0] out_q,
  output logic                     valid_q,
`ifdef ENCODER_ERR_CNT_EN
  output logic                     err_q,
  input  logic                     err_clr,
  output logic [7:0]               err_cnt
`else
  output logic                     err_q
`endif
);

  localparam int OW = $clog2(width);

  // Highest set bit wins, so multi-hot inputs resolve deterministically.
  function automatic logic [OW-1:0] top_index(input logic [width-1:0] v);
    logic [OW-1:0] idx;
    idx = {OW{1'b0}};
    for (int i = 0; i < width; i++) begin
      idx = v[i] ? OW'(i) : idx;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_hot(input logic [width-1:0] v);
    return (v & (v - width'(1))) != {width{1'b0}};
  endfunction

  logic [OW-1:0] out_d;
  logic          valid_d;
  logic          err_d;

  // Combinational encode and next-state values for the registered copy.
  always_comb begin
    out     = top_index(in);
    valid   = |in;
    err     = multi_hot(in);
    out_d   = out;
    valid_d = valid;
    err_d   = err;
  end

  // Registered copy of the combinational result, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= {OW{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef ENCODER_ERR_CNT_EN
  logic [7:0] err_cnt_d;
  logic [7:0] err_cnt_q;

  // Saturating count of error cycles; a clear takes priority over an increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'h00;
    end else if (err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_encoder_8_to_3.sv
// Scoreboard bench for encoder_8_to_3: combinational outputs checked after each drive,
// registered outputs checked by an independent monitor popping expected values from a queue.
module tb_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] out;
  logic       valid;
  logic       err;
  logic [2:0] out_q;
  logic       valid_q;
  logic       err_q;
`ifdef ENCODER_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  encoder_8_to_3 #(.width(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .out     (out),
    .valid   (valid),
    .err     (err),
    .out_q   (out_q),
    .valid_q (valid_q),
`ifdef ENCODER_ERR_CNT_EN
    .err_q   (err_q),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
`else
    .err_q   (err_q)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: index of the highest set bit is floor(log2(v)); zero maps to 0.
  function automatic int m_idx(input int v);
    int n;
    n = 0;
    while (v > 1) begin
      v = v / 2;
      n++;
    end
    return n;
  endfunction

  function automatic logic [4:0] m_all(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'(m_idx(int'(v)));
    return {idx, (v != 8'h00), ($countones(v) > 1)};
  endfunction

  task automatic apply(input logic [7:0] v);
    logic [4:0] e;
    @(negedge clk);
    din = v;
    e = m_all(v);
    exp_q.push_back(e);
    #1;
    check("out", {29'd0, out}, {29'd0, e[4:2]});
    check("valid", {31'd0, valid}, {31'd0, e[1]});
    check("err", {31'd0, err}, {31'd0, e[0]});
  endtask

  // Monitor: registered outputs are presented every rising edge outside reset.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_q", {29'd0, out_q}, {29'd0, e[4:2]});
        check("valid_q", {31'd0, valid_q}, {31'd0, e[1]});
        check("err_q", {31'd0, err_q}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    int k;
    logic [7:0] v;
    rst_n = 1'b0;
    din   = 8'h00;
`ifdef ENCODER_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    #2;
    check("rst_out_q", {29'd0, out_q}, 32'd0);
    check("rst_valid_q", {31'd0, valid_q}, 32'd0);
    check("rst_err_q", {31'd0, err_q}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
`ifdef ENCODER_ERR_CNT_EN
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      apply(v);
      check("sweep_k", {29'd0, out}, i);
    end

    for (int i = 0; i < 50; i++) begin
      k = $urandom_range(0, 7);
      v = 8'h01 << k;
      apply(v);
      check("rand_onehot", {29'd0, out}, k);
    end

    apply(8'h00);
    apply(8'h81);
    apply(8'h06);
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      apply(v);
    end

    // Reset asserted mid-cycle: registered outputs clear, combinational path keeps tracking.
    apply(8'h20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_q", {29'd0, out_q}, 32'd0);
    check("mid_rst_valid_q", {31'd0, valid_q}, 32'd0);
    check("mid_rst_err_q", {31'd0, err_q}, 32'd0);
    check("mid_rst_out", {29'd0, out}, 32'd5);
    @(posedge clk);
    #1;
    check("held_rst_out_q", {29'd0, out_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(m_all(8'h20));

`ifdef ENCODER_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      apply(8'h81);
    end
    @(negedge clk);
    check("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    check("err_cnt_clr", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    err_clr = 1'b0;
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
